regfile_bist: RTL and testbench

REGFILE_BIST -- requirements
Module: regfile_bist

---
 rtl/regfile_bist_pkg.sv | 21 ++
 rtl/regfile_bist_pattern.sv | 17 +
 rtl/regfile_bist.sv | 149 ++++++++++++++
 tb/tb_regfile_bist.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bist_pkg.sv
// Shared constants, state encoding and pattern helper for the regfile BIST.
// Optional second inverted pass is enabled by defining REGFILE_BIST_INVERT_EN.
package regfile_bist_pkg;

    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  ZERO_REG = 5'd31;
    localparam logic [63:0] PAT_MULT = 64'h0000010204080001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The multiplier spreads the index into several byte lanes of the word.
    function automatic logic [63:0] patOf(input logic [4:0] i);
        return {59'd0, i} * PAT_MULT;
    endfunction

endpackage

// File: rtl/regfile_bist_pattern.sv
// Combinational pattern generator: index and invert flag in, expected/write word out.
// With zeroMask set, index ZERO_REG yields 0 because X31 always reads as zero.
module regfile_bist_pattern
    import regfile_bist_pkg::*;
(
    input  logic [4:0]  index,
    input  logic        invert,
    input  logic        zeroMask,
    output logic [63:0] expVal
);

    logic [63:0] patVal;

    assign patVal = invert ? ~patOf(index) : patOf(index);
    assign expVal = (zeroMask && (index == ZERO_REG)) ? 64'd0 : patVal;

endmodule

// File: rtl/regfile_bist.sv
// Register-file built-in self-test: writes a pattern to all 32 registers, reads them back.
// Define REGFILE_BIST_INVERT_EN to add a second write/check pass using the inverted pattern.
module regfile_bist
    import regfile_bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic        RegWrite,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_reg,
    output logic [7:0]  err_count,
    output logic [1:0]  dbgState
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_CHECK = CHECK;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    logic [1:0]  state;
    logic [4:0]  idx;
    logic        invPass;
    logic        isWrite;
    logic        isCheck;
    logic        lastIdx;
    logic [4:0]  mirrorIdx;
    logic [63:0] val1;
    logic [63:0] exp2;
    logic        mis1;
    logic        mis2;
    logic [1:0]  errInc;
    logic [8:0]  errSum;
    logic [7:0]  errNext;

    assign isWrite   = (state == ST_WRITE);
    assign isCheck   = (state == ST_CHECK);
    assign lastIdx   = (idx == LAST_IDX);
    assign mirrorIdx = ZERO_REG - idx;

    // Port-1 instance serves both the write data and the port-1 expectation.
    regfile_bist_pattern u_pat1 (
        .index    (idx),
        .invert   (invPass),
        .zeroMask (isCheck),
        .expVal   (val1)
    );

    regfile_bist_pattern u_pat2 (
        .index    (mirrorIdx),
        .invert   (invPass),
        .zeroMask (1'b1),
        .expVal   (exp2)
    );

    assign RegWrite      = isWrite;
    assign WriteRegister = isWrite ? idx  : 5'd0;
    assign WriteData     = isWrite ? val1 : 64'd0;
    assign ReadRegister1 = isCheck ? idx       : 5'd0;
    assign ReadRegister2 = isCheck ? mirrorIdx : 5'd0;
    assign busy          = isWrite | isCheck;
    assign done          = (state == ST_DONE);
    assign dbgState      = state;

    assign mis1    = isCheck && (ReadData1 != val1);
    assign mis2    = isCheck && (ReadData2 != exp2);
    assign errInc  = {1'b0, mis1} + {1'b0, mis2};
    assign errSum  = {1'b0, err_count} + {7'd0, errInc};
    assign errNext = errSum[8] ? 8'hFF : errSum[7:0];

`ifdef REGFILE_BIST_INVERT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            invPass <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            invPass <= 1'b0;
        end else if (isCheck && lastIdx && !invPass) begin
            invPass <= 1'b1;
        end
    end
`else
    assign invPass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= 5'd0;
            err_count <= 8'd0;
            fail_reg  <= 5'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_WRITE;
                        idx       <= 5'd0;
                        err_count <= 8'd0;
                        fail_reg  <= 5'd0;
                        pass      <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    idx <= idx + 5'd1;
                    if (lastIdx) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    idx       <= idx + 5'd1;
                    err_count <= errNext;
                    // err_count only grows during a run, so zero means nothing captured yet.
                    if (err_count == 8'd0 && (mis1 || mis2)) begin
                        fail_reg <= mis1 ? idx : mirrorIdx;
                    end
                    if (lastIdx) begin
`ifdef REGFILE_BIST_INVERT_EN
                        if (!invPass) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_DONE;
                            pass  <= (errNext == 8'd0);
                        end
`else
                        state <= ST_DONE;
                        pass  <= (errNext == 8'd0);
`endif
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: behavioural regfile with injectable stuck-at faults,
// fixed vector table, randomized faults against a reference model, and corner sequences.
module tb_regfile_bist;

    localparam logic [63:0] MULT = 64'h0000010204080001;
`ifdef REGFILE_BIST_INVERT_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int BUSY_CYCLES = 64 * PASSES;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  fail_reg;
    logic [7:0]  err_count;
    logic [1:0]  dbgState;

    regfile_bist dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_reg      (fail_reg),
        .err_count     (err_count),
        .dbgState      (dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached regfile model: stuck-at bits applied on write, X31 reads zero unless faulted.
    logic [63:0] rf [32];
    logic [63:0] stuckMask [32];
    logic [63:0] stuckVal [32];
    logic        x31Stores;
    logic        scrub;

    always @(posedge clk) begin
        if (scrub) begin
            for (int r = 0; r < 32; r++) rf[r] <= {$urandom(), $urandom()};
        end else if (RegWrite) begin
            rf[WriteRegister] <= (WriteData & ~stuckMask[WriteRegister]) |
                                 (stuckVal[WriteRegister] & stuckMask[WriteRegister]);
        end
    end

    assign ReadData1 = (ReadRegister1 == 5'd31 && !x31Stores) ? 64'd0 : rf[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == 5'd31 && !x31Stores) ? 64'd0 : rf[ReadRegister2];

    int checks = 0;
    int failures = 0;
    logic [68:0] exp_q[$];
    int writeErrs = 0;
    logic [63:0] lastReg1;

    typedef struct {
        bit x31;
        int ra; int ba; bit va;
        int rb; int bb; bit vb;
        bit ePass; int eFail; int eErr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [63:0] v;
        v = 64'(i) * MULT;
        return v;
    endfunction

    function automatic logic [63:0] written(input int p, input int k);
        return (p == 1) ? ~pat(k) : pat(k);
    endfunction

    function automatic logic [63:0] stored(input int k, input logic [63:0] w);
        return (w & ~stuckMask[k]) | (stuckVal[k] & stuckMask[k]);
    endfunction

    task automatic clearFaults();
        for (int r = 0; r < 32; r++) begin
            stuckMask[r] = 64'd0;
            stuckVal[r]  = 64'd0;
        end
        x31Stores = 1'b0;
    endtask

    task automatic addFault(input int r, input int b, input bit v);
        stuckMask[r][b] = 1'b1;
        stuckVal[r][b]  = v;
    endtask

    // Reference: what each read should return vs. what the faulty regfile holds.
    task automatic predict(output bit ePass, output int eFail, output int eErr);
        logic [63:0] want1, want2, got1, got2;
        bit found;
        eErr = 0; eFail = 0; found = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < 32; i++) begin
                int j;
                j = 31 - i;
                want1 = (i == 31) ? 64'd0 : written(p, i);
                want2 = (j == 31) ? 64'd0 : written(p, j);
                got1  = (i == 31 && !x31Stores) ? 64'd0 : stored(i, written(p, i));
                got2  = (j == 31 && !x31Stores) ? 64'd0 : stored(j, written(p, j));
                if (got1 != want1) eErr++;
                if (got2 != want2) eErr++;
                if (!found && got1 != want1) begin eFail = i; found = 1; end
                else if (!found && got2 != want2) begin eFail = j; found = 1; end
            end
        end
        if (eErr > 255) eErr = 255;
        ePass = (eErr == 0);
    endtask

    task automatic loadExp();
        exp_q.delete();
        for (int p = 0; p < PASSES; p++)
            for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), written(p, k)});
    endtask

    task automatic runBist(input int startAgainAt, output int busyCyc, output int doneCnt,
                           output bit timedOut);
        logic [68:0] e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busyCyc = 0; doneCnt = 0; timedOut = 1;
        for (int c = 0; c < BUSY_CYCLES + 20; c++) begin
            if (busy) busyCyc++;
            if (done) doneCnt++;
            if (RegWrite) begin
                if (exp_q.size() == 0) writeErrs++;
                else begin
                    e = exp_q.pop_front();
                    if ({WriteRegister, WriteData} !== e) writeErrs++;
                end
                if (WriteRegister == 5'd1) lastReg1 = WriteData;
            end
            start = (startAgainAt > 0 && busyCyc == startAgainAt) ? 1'b1 : 1'b0;
            if (doneCnt > 0 && !busy && !done) begin
                timedOut = 0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) doneCnt++;
        end
    endtask

    task automatic runCase(input string name, input bit ePass, input int eFail, input int eErr,
                           input int startAgainAt);
        int busyCyc, doneCnt, errsBefore;
        bit tmo;
        loadExp();
        errsBefore = writeErrs;
        runBist(startAgainAt, busyCyc, doneCnt, tmo);
        check({name, ".timeout"}, tmo, 0);
        check({name, ".busyCycles"}, busyCyc, BUSY_CYCLES);
        check({name, ".doneCount"}, doneCnt, 1);
        check({name, ".pass"}, pass, ePass);
        check({name, ".fail_reg"}, fail_reg, eFail);
        check({name, ".err_count"}, err_count, eErr);
        check({name, ".writeStream"}, writeErrs - errsBefore, 0);
        check({name, ".writesLeft"}, exp_q.size(), 0);
    endtask

    initial begin
        bit mp;
        int mf, me, nf, c10;
        bit seen10;

`ifdef REGFILE_BIST_INVERT_EN
        vecs[0] = '{0, -1, 0, 0, -1, 0, 0, 1, 0, 0};
        vecs[1] = '{1, -1, 0, 0, -1, 0, 0, 0, 31, 4};
        vecs[2] = '{0, 5, 0, 0, -1, 0, 0, 0, 5, 2};
        vecs[3] = '{0, 0, 63, 1, -1, 0, 0, 0, 0, 2};
        vecs[4] = '{0, 20, 3, 0, -1, 0, 0, 0, 20, 2};
        vecs[5] = '{0, 4, 2, 0, 27, 0, 0, 0, 4, 4};
        vecs[6] = '{0, 30, 1, 0, -1, 0, 0, 0, 30, 2};
`else
        vecs[0] = '{0, -1, 0, 0, -1, 0, 0, 1, 0, 0};
        vecs[1] = '{1, -1, 0, 0, -1, 0, 0, 0, 31, 2};
        vecs[2] = '{0, 5, 0, 0, -1, 0, 0, 0, 5, 2};
        vecs[3] = '{0, 0, 63, 1, -1, 0, 0, 0, 0, 2};
        vecs[4] = '{0, 20, 3, 0, -1, 0, 0, 1, 0, 0};
        vecs[5] = '{0, 4, 2, 0, 27, 0, 0, 0, 4, 4};
        vecs[6] = '{0, 30, 1, 0, -1, 0, 0, 0, 30, 2};
`endif

        clearFaults();
        lastReg1 = 64'd0;
        reset = 1'b1; start = 1'b0; scrub = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; scrub = 1'b0;

        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.pass", pass, 0);
        check("reset.RegWrite", RegWrite, 0);
        check("reset.err_count", err_count, 0);
        check("reset.fail_reg", fail_reg, 0);
        check("reset.addrs", {ReadRegister1, ReadRegister2, WriteRegister}, 0);
        check("reset.WriteData", WriteData, 0);
        check("reset.state", dbgState, 0);

        for (int v = 0; v < 7; v++) begin
            clearFaults();
            x31Stores = vecs[v].x31;
            if (vecs[v].ra >= 0) addFault(vecs[v].ra, vecs[v].ba, vecs[v].va);
            if (vecs[v].rb >= 0) addFault(vecs[v].rb, vecs[v].bb, vecs[v].vb);
            runCase($sformatf("vec%0d", v), vecs[v].ePass, vecs[v].eFail, vecs[v].eErr, 0);
        end

        // Results hold until the next start, then reset clears them.
        clearFaults();
        x31Stores = 1'b1;
        runCase("holdRun", 0, 31, 2 * PASSES, 0);
        repeat (5) @(posedge clk);
        #1;
        check("hold.err_count", err_count, 2 * PASSES);
        check("hold.fail_reg", fail_reg, 31);
        check("hold.pass", pass, 0);
        check("hold.idleOutputs", {RegWrite, ReadRegister1, ReadRegister2, WriteRegister}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("resetClear.err_count", err_count, 0);
        check("resetClear.fail_reg", fail_reg, 0);

        clearFaults();
        runCase("goodInvertCheck", 1, 0, 0, 0);
`ifdef REGFILE_BIST_INVERT_EN
        check("reg1LastWrite", lastReg1, 64'hFFFFFEFDFBF7FFFE);
`else
        check("reg1LastWrite", lastReg1, 64'h0000010204080001);
`endif

        runCase("startWhileBusy", 1, 0, 0, 20);

        // Abort during WRITE idx 10: the write at the reset edge must still land.
        clearFaults();
        scrub = 1'b1;
        @(posedge clk); #1;
        scrub = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen10 = 0;
        for (int c = 0; c < 40; c++) begin
            if (RegWrite && WriteRegister == 5'd10) begin
                seen10 = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort.reachedIdx10", seen10, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.RegWrite", RegWrite, 0);
        check("abort.busy", busy, 0);
        check("abort.reg10Committed", rf[10], pat(10));
        c10 = 0;
        for (int c = 0; c < BUSY_CYCLES + 10; c++) begin
            if (done || busy) c10++;
            @(posedge clk); #1;
        end
        check("abort.noDoneOrBusy", c10, 0);
        runCase("afterAbort", 1, 0, 0, 0);

        // Reset wins over start on the same edge.
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("resetVsStart.busy", busy, 0);
        @(posedge clk); #1;
        check("resetVsStart.state", dbgState, 0);

        for (int n = 0; n < 10; n++) begin
            clearFaults();
            x31Stores = ($urandom_range(0, 3) == 0);
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++)
                addFault($urandom_range(0, 31), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
            predict(mp, mf, me);
            runCase($sformatf("rand%0d", n), mp, mf, me, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1);
    end

endmodule
